// File: rtl/simple_des_feeder.sv
// Serial byte feeder for a 16-bit DES stage: pairs {key, plaintext} bytes, queues them,
// presents each pair on des_word for a fixed settle time and captures the returned ciphertext.
module simple_des_feeder #(
    parameter int WAIT_CYCLES = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] des_word,
    input  logic [7:0]  cipher_in,
    output logic [7:0]  result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic [2:0]  fifo_count
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(FIFO_DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST_C = PTRW'(FIFO_DEPTH - 1);
    localparam logic [3:0]      WAIT_LOAD_C = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        key_q, key_d;
    logic [PTRW-1:0]   wrPtr_q, wrPtr_d;
    logic [PTRW-1:0]   rdPtr_q, rdPtr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [15:0]       desWord_q, desWord_d;
    logic [7:0]        result_q, result_d;
    logic              resultValid_q, resultValid_d;
    logic [15:0]       fifoMem [FIFO_DEPTH];

    logic accept;
    logic push;
    logic doPop;
    logic doCapture;
    logic doDeliver;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT;
            S_WAIT:  if (waitCnt_q == '0) state_d = S_OUT;
            S_OUT:   if (result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        doPop     = (state_q == S_LOAD);
        doCapture = (state_q == S_WAIT) && (waitCnt_q == '0);
        doDeliver = (state_q == S_OUT) && result_ready;
    end

    // Byte intake runs independently of the FSM; only a full FIFO stalls it.
    always_comb begin
        byte_ready = (count_q < DEPTH_C);
        accept     = byte_valid && byte_ready;
        push       = accept && phase_q;

        phase_d = accept ? ~phase_q : phase_q;
        key_d   = (accept && !phase_q) ? byte_in : key_q;

        wrPtr_d = wrPtr_q;
        if (push) wrPtr_d = (wrPtr_q == PTR_LAST_C) ? '0 : wrPtr_q + 1'b1;
        rdPtr_d = rdPtr_q;
        if (doPop) rdPtr_d = (rdPtr_q == PTR_LAST_C) ? '0 : rdPtr_q + 1'b1;

        count_d = count_q;
        if (push && !doPop) count_d = count_q + 1'b1;
        else if (!push && doPop) count_d = count_q - 1'b1;

        waitCnt_d = waitCnt_q;
        if (doPop) waitCnt_d = WAIT_LOAD_C;
        else if ((state_q == S_WAIT) && (waitCnt_q != '0)) waitCnt_d = waitCnt_q - 1'b1;

        desWord_d     = doPop ? fifoMem[rdPtr_q] : desWord_q;
        result_d      = doCapture ? cipher_in : result_q;
        resultValid_d = resultValid_q;
        if (doCapture) resultValid_d = 1'b1;
        else if (doDeliver) resultValid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= 1'b0;
            key_q         <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            waitCnt_q     <= '0;
            desWord_q     <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            key_q         <= key_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            waitCnt_q     <= waitCnt_d;
            desWord_q     <= desWord_d;
            result_q      <= result_d;
            resultValid_q <= resultValid_d;
        end
    end

    // Queue storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr_q] <= {key_q, byte_in};
    end

    assign des_word     = desWord_q;
    assign result       = result_q;
    assign result_valid = resultValid_q;
    assign fifo_count   = 3'(count_q);

endmodule

// File: tb/tb_simple_des_feeder.sv
// Scoreboard bench for simple_des_feeder: a byte-pairing model queues expected results,
// and a negedge monitor checks every delivered ciphertext against the queue head.
module tb_simple_des_feeder;

    localparam int WAITC = 6;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic [15:0] desWord;
    logic [7:0]  cipherIn = 8'h00;
    logic [7:0]  result;
    logic        resultValid;
    logic        resultReady;
    logic        busy;
    logic [2:0]  fifoCount;

    typedef struct {
        logic [15:0] des;
        logic [7:0]  res;
    } expEntry_t;

    expEntry_t expQ[$];
    int        deliverTimes[$];
    int        testsRun = 0;
    int        testsFailed = 0;
    int        cycleCount = 0;
    bit        haveKey;
    logic [7:0] pendingKey;
    bit        randomReady;

    simple_des_feeder #(.WAIT_CYCLES(WAITC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_in      (byteIn),
        .byte_valid   (byteValid),
        .byte_ready   (byteReady),
        .des_word     (desWord),
        .cipher_in    (cipherIn),
        .result       (result),
        .result_valid (resultValid),
        .result_ready (resultReady),
        .busy         (busy),
        .fifo_count   (fifoCount)
    );

    always #5 clk = ~clk;

    // DES stand-in: XOR of the two halves, one register stage behind des_word.
    always @(posedge clk) cipherIn <= desWord[15:8] ^ desWord[7:0];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Reference pairing: every second accepted byte closes a {key, plaintext} pair.
    task automatic modelAccept(input logic [7:0] b);
        if (!haveKey) begin
            pendingKey = b;
            haveKey = 1'b1;
        end else begin
            expQ.push_back('{des: {pendingKey, b}, res: pendingKey ^ b});
            haveKey = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int stall = 0;
        byteIn = b;
        byteValid = 1'b1;
        forever begin
            @(negedge clk);
            if (byteReady) break;
            stall++;
            if (stall > 200) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL byteAcceptTimeout: byte 0x%0h still not accepted, required acceptance", b);
                break;
            end
            @(posedge clk);
            #1;
            if (randomReady) resultReady = 1'($urandom_range(0, 1));
        end
        if (stall <= 200) modelAccept(b);
        @(posedge clk);
        #1;
        byteValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        randomReady = 1'b0;
        resultReady = 1'b1;
        @(negedge clk);
        while ((busy || fifoCount != 3'd0 || expQ.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drainTimeout: %0d results outstanding, required 0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        expEntry_t e;
        cycleCount++;
        if (!reset && resultValid && resultReady) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedResult: got result 0x%0h, required no result", result);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", 32'(result), 32'(e.res));
                checkOutput("desWord", 32'(desWord), 32'(e.des));
                deliverTimes.push_back(cycleCount);
            end
        end
    end

    initial begin
        int cycles;
        int bad;
        logic [7:0] b11;

        byteIn = 8'h00;
        byteValid = 1'b0;
        resultReady = 1'b0;
        randomReady = 1'b0;
        haveKey = 1'b0;
        pendingKey = 8'h00;

        // Reset is checked before the first clock edge to prove it acts asynchronously.
        #1 reset = 1'b1;
        #2;
        checkOutput("resetDesWord", 32'(desWord), 0);
        checkOutput("resetResult", 32'(result), 0);
        checkOutput("resetValid", 32'(resultValid), 0);
        checkOutput("resetBusy", 32'(busy), 0);
        checkOutput("resetCount", 32'(fifoCount), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", 32'(byteReady), 1);
        @(posedge clk);
        #1;

        // Single pair and its latency from the LOAD edge.
        resultReady = 1'b1;
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        cycles = 0;
        @(negedge clk);
        while (!busy && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        cycles = 0;
        while (!resultValid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(WAITC + 1));
        @(negedge clk);
        checkOutput("busyAfterDeliver", 32'(busy), 0);
        @(posedge clk);
        #1;
        waitIdle();

        // Ordering and per-pair spacing with the queue kept non-empty.
        deliverTimes.delete();
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        applyStimulus(8'h55); applyStimulus(8'h66);
        waitIdle();
        checkOutput("deliverCount", 32'(deliverTimes.size()), 3);
        if (deliverTimes.size() == 3) begin
            checkOutput("spacing12", 32'(deliverTimes[1] - deliverTimes[0]), 32'(WAITC + 3));
            checkOutput("spacing23", 32'(deliverTimes[2] - deliverTimes[1]), 32'(WAITC + 3));
        end

        // Fill with consumer stalled, then hold in OUT under back-pressure.
        resultReady = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(8'($urandom));
        cycles = 0;
        @(negedge clk);
        while (!resultValid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("fullCount", 32'(fifoCount), 32'(DEPTH));
        checkOutput("fullNotReady", 32'(byteReady), 0);
        @(posedge clk);
        #1;
        b11 = 8'($urandom);
        byteIn = b11;
        byteValid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!resultValid || byteReady || fifoCount != 3'(DEPTH) || expQ.size() == 0 ||
                result != expQ[0].res || desWord != expQ[0].des) bad++;
            @(posedge clk);
            #1;
        end
        checkOutput("holdStableCycles", 32'(bad), 0);
        resultReady = 1'b1;
        @(posedge clk);
        #1;
        resultReady = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterHandshake", 32'(busy), 0);
        checkOutput("validClearedAfterHandshake", 32'(resultValid), 0);
        checkOutput("stillFullAfterHandshake", 32'(byteReady), 0);
        @(posedge clk);
        #1;
        applyStimulus(b11);
        resultReady = 1'b1;
        applyStimulus(8'($urandom));
        waitIdle();

        // Plaintext accepted in the LOAD cycle while exactly one pair is queued.
        applyStimulus(8'h5E); applyStimulus(8'h21);
        applyStimulus(8'h9B); applyStimulus(8'h64);
        @(negedge clk);
        checkOutput("pushPopCount", 32'(fifoCount), 1);
        checkOutput("pushPopBusy", 32'(busy), 1);
        @(posedge clk);
        #1;
        waitIdle();

        // Asynchronous reset in mid-WAIT with a queued pair and a dangling key byte.
        applyStimulus(8'hC3); applyStimulus(8'h5A);
        applyStimulus(8'h0F); applyStimulus(8'hF0);
        applyStimulus(8'h77);
        @(negedge clk);
        #2 reset = 1'b1;
        expQ.delete();
        haveKey = 1'b0;
        #1;
        checkOutput("midResetDesWord", 32'(desWord), 0);
        checkOutput("midResetResult", 32'(result), 0);
        checkOutput("midResetValid", 32'(resultValid), 0);
        checkOutput("midResetBusy", 32'(busy), 0);
        checkOutput("midResetCount", 32'(fifoCount), 0);
        checkOutput("midResetReady", 32'(byteReady), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterMidReset", 32'(byteReady), 1);
        @(posedge clk);
        #1;
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        waitIdle();

        // Randomised traffic with a randomly stalling consumer.
        randomReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int gap = $urandom_range(0, 3);
            repeat (gap) begin
                resultReady = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            resultReady = 1'($urandom_range(0, 1));
            applyStimulus(8'($urandom));
        end
        waitIdle();

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
